// File: rtl/bist_sequencer.sv
// Purpose : sequences a Sobel-pipeline BIST run: clear signature, seed LFSR, run, drain, compare.
// Latency : start to DONE = 3 + RUN cycles + DRAIN_CYC + 1; status held in DONE until start/abort/reset.
// Backpressure: none; start_i is ignored while busy_o=1, abort_i returns to IDLE on the next edge.
//
// Ports: clk_i/reset_i (async active-high); start_i/abort_i control; seed_i, golden_i, num_px_i
// captured on an accepted start; px_rdy_i, lfsr_done_i, signature_i observe the datapath;
// sa_clear_o/sa_en_o drive the signature analyzer; lfsr_cfg_o/lfsr_seed_o/lfsr_en_o drive the LFSR;
// busy_o/done_o/pass_o/fail_o/timeout_o report status.
// Optional: define BIST_WATCHDOG_EN to bound RUN to WDOG_CYC cycles (timeout_o then reports it).
module bist_sequencer #(
    parameter int DATA_W    = 24,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 8,
    parameter int WDOG_CYC  = 65535
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [DATA_W-1:0] golden_i,
    input  logic [CNT_W-1:0]  num_px_i,
    input  logic              px_rdy_i,
    input  logic              lfsr_done_i,
    input  logic [DATA_W-1:0] signature_i,
    output logic              sa_clear_o,
    output logic              sa_en_o,
    output logic              lfsr_cfg_o,
    output logic [DATA_W-1:0] lfsr_seed_o,
    output logic              lfsr_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEED, S_RUN, S_DRAIN, S_COMPARE, S_DONE
    } state_t;

    localparam int DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t            state_q, state_d;
    logic [DR_W-1:0]   drain_cnt_q;
    logic [CNT_W-1:0]  px_cnt_q, num_px_q;
    logic [DATA_W-1:0] seed_q, golden_q;
    logic              underrun_q, pass_q, timeout_q;

    logic start_ok, cnt_hit, drain_last, wdog_hit, underrun_set;

    assign start_ok   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    // The pixel arriving in this cycle is the last one needed.
    assign cnt_hit    = px_rdy_i &&
                        (({1'b0, px_cnt_q} + (CNT_W+1)'(1)) == {1'b0, num_px_q});
    assign drain_last = (drain_cnt_q == DR_W'(DRAIN_CYC - 1));
    // Count completion beats an LFSR that runs out in the same cycle.
    assign underrun_set = (state_q == S_RUN) && !cnt_hit && lfsr_done_i;

`ifdef BIST_WATCHDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC + 1) : 1;
    logic [WD_W-1:0] wdog_cnt_q;

    assign wdog_hit = (state_q == S_RUN) && (wdog_cnt_q == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (abort_i || start_ok) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (state_q == S_RUN) begin
            wdog_cnt_q <= wdog_cnt_q + WD_W'(1);
            if (wdog_hit && !cnt_hit && !lfsr_done_i)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wdog_hit  = 1'b0;
    assign timeout_q = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_SEED;
            S_SEED:    state_d = (num_px_q == '0) ? S_DRAIN : S_RUN;
            S_RUN:     if (cnt_hit || lfsr_done_i || wdog_hit) state_d = S_DRAIN;
            S_DRAIN:   if (drain_last) state_d = S_COMPARE;
            S_COMPARE: state_d = S_DONE;
            S_DONE:    if (start_ok) state_d = S_CLEAR;
            default:   state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            seed_q      <= '0;
            golden_q    <= '0;
            num_px_q    <= '0;
            px_cnt_q    <= '0;
            drain_cnt_q <= '0;
            underrun_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else if (abort_i) begin
            seed_q      <= '0;
            golden_q    <= '0;
            num_px_q    <= '0;
            px_cnt_q    <= '0;
            drain_cnt_q <= '0;
            underrun_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else if (start_ok) begin
            seed_q      <= seed_i;
            golden_q    <= golden_i;
            num_px_q    <= num_px_i;
            px_cnt_q    <= '0;
            drain_cnt_q <= '0;
            underrun_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (px_rdy_i && (px_cnt_q != {CNT_W{1'b1}}))
                        px_cnt_q <= px_cnt_q + CNT_W'(1);
                    if (underrun_set)
                        underrun_q <= 1'b1;
                end
                S_DRAIN:
                    drain_cnt_q <= drain_last ? '0 : drain_cnt_q + DR_W'(1);
                S_COMPARE:
                    pass_q <= (signature_i == golden_q) && !underrun_q && !timeout_q;
                default: ;
            endcase
        end
    end

    // Strobes and status decode from state; pass/fail only ever show in DONE.
    assign sa_clear_o  = (state_q == S_CLEAR);
    assign lfsr_cfg_o  = (state_q == S_SEED);
    assign lfsr_en_o   = (state_q == S_RUN);
    assign sa_en_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = (state_q == S_DONE) && pass_q;
    assign fail_o      = (state_q == S_DONE) && !pass_q;
    assign lfsr_seed_o = seed_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Purpose : directed self-checking bench for bist_sequencer.
// Latency : n/a.
// Backpressure: n/a.
module tb_bist_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, abort_i, px_rdy_i, lfsr_done_i;
    logic [23:0] seed_i, golden_i, signature_i;
    logic [15:0] num_px_i;
    logic        sa_clear_o, sa_en_o, lfsr_cfg_o, lfsr_en_o;
    logic [23:0] lfsr_seed_o;
    logic        busy_o, done_o, pass_o, fail_o, timeout_o;

    bist_sequencer #(.DATA_W(24), .CNT_W(16), .DRAIN_CYC(8), .WDOG_CYC(20)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .seed_i(seed_i), .golden_i(golden_i), .num_px_i(num_px_i),
        .px_rdy_i(px_rdy_i), .lfsr_done_i(lfsr_done_i), .signature_i(signature_i),
        .sa_clear_o(sa_clear_o), .sa_en_o(sa_en_o), .lfsr_cfg_o(lfsr_cfg_o),
        .lfsr_seed_o(lfsr_seed_o), .lfsr_en_o(lfsr_en_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    wire [32:0] all_outs = {lfsr_seed_o, sa_clear_o, sa_en_o, lfsr_cfg_o, lfsr_en_o,
                            busy_o, done_o, pass_o, fail_o, timeout_o};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the DUT in CLEAR (cycle t+1) when the start is accepted.
    task automatic start_run(input logic [15:0] np, input logic [23:0] seed);
        seed_i   = seed;
        num_px_i = np;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic pulse_px(input int n);
        px_rdy_i = 1'b1;
        repeat (n) tick();
        px_rdy_i = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done_o && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_reached", 40'(done_o), 40'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen_en;

        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; px_rdy_i = 1'b0;
        lfsr_done_i = 1'b0; seed_i = '0; num_px_i = '0;
        golden_i = 24'h00A5C3; signature_i = 24'h00A5C3;
        repeat (2) tick();
        chk("reset_outs", 40'(all_outs), 40'(0));
        reset_i = 1'b0;

        // Normal pass run: strobe timing, drain length, result hold.
        start_run(16'd4, 24'h123456);
        chk("t1_clear", 40'({sa_clear_o, lfsr_cfg_o, busy_o, lfsr_en_o}), 40'(4'b1010));
        tick();
        chk("t1_seed", 40'({sa_clear_o, lfsr_cfg_o, lfsr_en_o}), 40'(3'b010));
        chk("t1_seed_val", 40'(lfsr_seed_o), 40'(24'h123456));
        tick();
        chk("t1_run", 40'({lfsr_en_o, sa_en_o}), 40'(2'b11));
        pulse_px(2);
        tick();
        chk("t1_run_hold", 40'(lfsr_en_o), 40'(1));
        pulse_px(2);
        chk("t1_drain", 40'({lfsr_en_o, sa_en_o, busy_o}), 40'(3'b011));
        repeat (7) tick();
        chk("t1_drain_end", 40'({sa_en_o, busy_o}), 40'(2'b11));
        tick();
        chk("t1_compare", 40'({sa_en_o, busy_o, done_o}), 40'(3'b010));
        tick();
        chk("t1_done", 40'({done_o, pass_o, fail_o, busy_o}), 40'(4'b1100));
        repeat (3) tick();
        chk("t1_hold", 40'({done_o, pass_o, fail_o, busy_o}), 40'(4'b1100));

        // Signature mismatch.
        signature_i = 24'h00A5C2;
        start_run(16'd4, 24'h0F0F0F);
        repeat (2) tick();
        pulse_px(4);
        wait_done();
        chk("t2_fail", 40'({done_o, pass_o, fail_o}), 40'(3'b101));

        // Zero pixels: RUN skipped, DONE at t+12.
        signature_i = 24'h00A5C3;
        start_run(16'd0, 24'h00ABCD);
        lat = 1;
        seen_en = lfsr_en_o;
        while (!done_o && lat < 100) begin
            tick();
            lat++;
            seen_en = seen_en | lfsr_en_o;
        end
        chk("t3_latency", 40'(lat), 40'(12));
        chk("t3_no_lfsr_en", 40'(seen_en), 40'(0));
        chk("t3_pass", 40'({done_o, pass_o}), 40'(2'b11));

        // LFSR exhausted early: underrun fails despite matching signature.
        start_run(16'd10, 24'h111111);
        repeat (2) tick();
        pulse_px(3);
        lfsr_done_i = 1'b1;
        tick();
        lfsr_done_i = 1'b0;
        chk("t4_drain", 40'({lfsr_en_o, sa_en_o}), 40'(2'b01));
        wait_done();
        chk("t4_underrun_fail", 40'({done_o, pass_o, fail_o}), 40'(3'b101));

        // Count reached and LFSR done in the same cycle: no underrun.
        start_run(16'd2, 24'h222222);
        repeat (2) tick();
        px_rdy_i = 1'b1;
        tick();
        lfsr_done_i = 1'b1;
        tick();
        px_rdy_i = 1'b0;
        lfsr_done_i = 1'b0;
        wait_done();
        chk("t4b_tie_pass", 40'({done_o, pass_o, fail_o}), 40'(3'b110));

        // Start while busy is ignored; abort beats start.
        start_run(16'd8, 24'h654321);
        repeat (2) tick();
        start_i = 1'b1;
        seed_i  = 24'hFFFFFF;
        tick();
        start_i = 1'b0;
        chk("t5_start_ignored", 40'({lfsr_cfg_o, lfsr_en_o, sa_clear_o}), 40'(3'b010));
        chk("t5_seed_kept", 40'(lfsr_seed_o), 40'(24'h654321));
        pulse_px(2);
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("t5_abort_outs", 40'(all_outs), 40'(0));
        tick();
        chk("t5_idle_hold", 40'(all_outs), 40'(0));

        // RUN with no pixels: watchdog (if built) or indefinite wait.
        start_run(16'd5, 24'h0A0A0A);
        repeat (2) tick();
`ifdef BIST_WATCHDOG_EN
        wait_done();
        chk("t6_timeout", 40'({done_o, pass_o, fail_o, timeout_o}), 40'(4'b1011));
        start_run(16'd5, 24'h13579B);
        repeat (2) tick();
`else
        repeat (30) tick();
        chk("t6_no_wdog", 40'({lfsr_en_o, timeout_o}), 40'(2'b10));
`endif

        // Asynchronous reset mid-RUN, then start on the first edge after release.
        pulse_px(1);
        chk("t7_in_run", 40'(lfsr_en_o), 40'(1));
        #3;
        reset_i = 1'b1;
        #1;
        chk("t7_async_reset", 40'(all_outs), 40'(0));
        tick();
        reset_i  = 1'b0;
        seed_i   = 24'h2468AC;
        num_px_i = 16'd1;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        chk("t7_start_after_reset", 40'({sa_clear_o, busy_o}), 40'(2'b11));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
